// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
// Shared definitions for the 7-segment display path:
//   - SYS_CLK_FREQ   : default system clock frequency in Hz
//   - code_t         : 5-bit display character code produced by the display
//                      controller (0..9, A, b, C, d, E, F, t, J, r, H(-), BLK)
//   - seg_pattern_t  : {a,b,c,d,e,f,g,dp}, active-high
//   - seg7_decode()  : code_t -> segment pattern with dp forced to 0
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

  localparam int SYS_CLK_FREQ = 100_000_000;

  typedef logic [4:0] code_t;

  localparam code_t CHAR_0   = 5'd0;
  localparam code_t CHAR_1   = 5'd1;
  localparam code_t CHAR_2   = 5'd2;
  localparam code_t CHAR_3   = 5'd3;
  localparam code_t CHAR_4   = 5'd4;
  localparam code_t CHAR_5   = 5'd5;
  localparam code_t CHAR_6   = 5'd6;
  localparam code_t CHAR_7   = 5'd7;
  localparam code_t CHAR_8   = 5'd8;
  localparam code_t CHAR_9   = 5'd9;
  localparam code_t CHAR_A   = 5'd10;
  localparam code_t CHAR_B   = 5'd11;  // lower-case b
  localparam code_t CHAR_C   = 5'd12;
  localparam code_t CHAR_D   = 5'd13;  // lower-case d
  localparam code_t CHAR_E   = 5'd14;
  localparam code_t CHAR_F   = 5'd15;
  localparam code_t CHAR_T   = 5'd16;  // lower-case t
  localparam code_t CHAR_J   = 5'd17;
  localparam code_t CHAR_R   = 5'd18;  // lower-case r
  localparam code_t CHAR_H   = 5'd19;  // dash, segment g only
  localparam code_t CHAR_BLK = 5'd31;

  typedef logic [7:0] seg_pattern_t;

  localparam seg_pattern_t SEG_BLANK = 8'h00;

  // Character lookup; unused codes 20..30 and BLK render blank.
  function automatic seg_pattern_t seg7_decode(input code_t code);
    logic [6:0] abcdefg;
    case (code)
      CHAR_0:  abcdefg = 7'b1111110;
      CHAR_1:  abcdefg = 7'b0110000;
      CHAR_2:  abcdefg = 7'b1101101;
      CHAR_3:  abcdefg = 7'b1111001;
      CHAR_4:  abcdefg = 7'b0110011;
      CHAR_5:  abcdefg = 7'b1011011;
      CHAR_6:  abcdefg = 7'b1011111;
      CHAR_7:  abcdefg = 7'b1110000;
      CHAR_8:  abcdefg = 7'b1111111;
      CHAR_9:  abcdefg = 7'b1111011;
      CHAR_A:  abcdefg = 7'b1110111;
      CHAR_B:  abcdefg = 7'b0011111;
      CHAR_C:  abcdefg = 7'b1001110;
      CHAR_D:  abcdefg = 7'b0111101;
      CHAR_E:  abcdefg = 7'b1001111;
      CHAR_F:  abcdefg = 7'b1000111;
      CHAR_T:  abcdefg = 7'b0001111;
      CHAR_J:  abcdefg = 7'b0111000;
      CHAR_R:  abcdefg = 7'b0000101;
      CHAR_H:  abcdefg = 7'b0000001;
      default: abcdefg = 7'b0000000;
    endcase
    return {abcdefg, 1'b0};
  endfunction

endpackage

// File: rtl/seg7_scan_driver_char_decoder.sv
// -----------------------------------------------------------------------------
// seg7_char_decoder
// Purely combinational code_t -> abcdefg lookup. Kept as its own block so a
// future LED/UART echo path can reuse the same character table.
// Ports:
//   i_code     in  5   character code
//   o_abcdefg  out 7   segments a..g, active-high
// -----------------------------------------------------------------------------
module seg7_char_decoder
  import seg7_scan_driver_pkg::*;
(
  input  code_t       i_code,
  output logic [6:0]  o_abcdefg
);

  // The lookup always returns dp=0; the decimal point is owned by the caller.
  logic w_unused_dp;

  assign {o_abcdefg, w_unused_dp} = seg7_decode(i_code);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Drives a time-multiplexed, active-high 7-segment bank from NUM_DIGITS code_t
// characters. New content is double-buffered (staging -> active) and only
// becomes visible at a frame boundary, so a frame is never torn.
//
// Parameters:
//   CLK_FREQ    input clock in Hz
//   DIGIT_HZ    dwell rate per digit; DIV = CLK_FREQ/DIGIT_HZ cycles (>= 2)
//   NUM_DIGITS  digits scanned (>= 2)
// Ports:
//   clk       in   1             clock
//   rst_n     in   1             synchronous reset, active-low
//   codes_i   in   NUM_DIGITS*5  packed code_t per digit, digit 0 rightmost
//   dp_i      in   NUM_DIGITS    decimal point per digit
//   update_i  in   1             strobe: capture codes_i/dp_i/blink_i
//   blink_i   in   NUM_DIGITS    per-digit blink mask (SEG7_BLINK_EN only)
//   an_o      out  NUM_DIGITS    digit enable, one-hot or all-zero
//   seg_o     out  8             {a,b,c,d,e,f,g,dp}
//   frame_o   out  1             pulse, coincides with an_o[0] rising
// Configuration macro:
//   SEG7_BLINK_EN  adds a 2 Hz blink phase that blanks masked digits.
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_FREQ   = SYS_CLK_FREQ,
  parameter int DIGIT_HZ   = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*5-1:0] codes_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    update_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [7:0]              seg_o,
  output logic                    frame_o
);

  localparam int DIV   = CLK_FREQ / DIGIT_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Scan divider and digit index
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_digit_end;
  logic             w_wrap;

  assign w_digit_end = (r_div_cnt == DIV_LAST);
  assign w_wrap      = w_digit_end && (r_idx == IDX_LAST);  // frame boundary

  // NOTE: clocked state uses <= so every register samples pre-edge values;
  // blocking = here would make later statements see already-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_digit_end) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Staging / active buffers
  // ---------------------------------------------------------------------------
  code_t w_in_code [NUM_DIGITS];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
    assign w_in_code[k] = codes_i[5*k +: 5];
  end

  code_t                 r_stage_code [NUM_DIGITS];
  code_t                 r_act_code   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_stage_dp;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic                  r_pending;
  logic                  w_bypass;
  logic                  w_commit;

  // An update landing on the boundary itself goes straight to active;
  // otherwise a pending staged update is committed at the boundary.
  assign w_bypass = w_wrap && update_i;
  assign w_commit = w_wrap && !update_i && r_pending;

  // NOTE: these small buffers are reset (unlike a plain storage RAM) because
  // the display must come up blank, never showing power-up garbage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_stage_code[k] <= CHAR_BLK;
        r_act_code[k]   <= CHAR_BLK;
      end
      r_stage_dp <= '0;
      r_act_dp   <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (update_i) begin
        r_stage_code <= w_in_code;
        r_stage_dp   <= dp_i;
      end

      if (w_bypass) begin
        r_act_code <= w_in_code;
        r_act_dp   <= dp_i;
      end else if (w_commit) begin
        r_act_code <= r_stage_code;
        r_act_dp   <= r_stage_dp;
      end

      // Every boundary leaves nothing pending: either committed, bypassed,
      // or there was nothing to do.
      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (update_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink: 2 Hz phase, blanks masked digits while high
  // ---------------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
  localparam int BLINK_DIV = CLK_FREQ / 4;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;
  logic [NUM_DIGITS-1:0] r_stage_blink;
  logic [NUM_DIGITS-1:0] r_act_blink;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Follows the same staging/commit rules as the code and dp buffers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_blink <= '0;
      r_act_blink   <= '0;
    end else begin
      if (update_i) begin
        r_stage_blink <= blink_i;
      end
      if (w_bypass) begin
        r_act_blink <= blink_i;
      end else if (w_commit) begin
        r_act_blink <= r_stage_blink;
      end
    end
  end
`else
  logic w_unused_blink;

  assign w_unused_blink = ^blink_i;
`endif

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [6:0]            w_abcdefg;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  seg7_char_decoder u_decoder (
    .i_code    (r_act_code[r_idx]),
    .o_abcdefg (w_abcdefg)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_an_next        = '0;
    w_an_next[r_idx] = 1'b1;
    w_seg_next       = {w_abcdefg, r_act_dp[r_idx]};
`ifdef SEG7_BLINK_EN
    if (r_blink_phase && r_act_blink[r_idx]) begin
      w_seg_next = SEG_BLANK;
    end
`endif
  end

  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;
  logic                  r_wrap_d;
  logic                  r_frame;

  // r_wrap_d marks the first cycle with idx=0; one more register stage lines
  // frame_o up with the registered an_o[0] rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an     <= '0;
      r_seg    <= SEG_BLANK;
      r_wrap_d <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_an     <= w_an_next;
      r_seg    <= w_seg_next;
      r_wrap_d <= w_wrap;
      r_frame  <= r_wrap_d;
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign frame_o = r_frame;

endmodule
